// File: rtl/fetch_packet_splitter.sv
// Splits each 128-bit fetch packet popped from the fetch/decode FIFO into up to
// two 32-bit instructions and issues them in order to a single-issue decoder.
module fetch_packet_splitter #(
  parameter int DATA_WIDTH = 128,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  output logic                  fifo_pop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [PC_WIDTH-1:0]   out_inst,
  output logic [CNT_WIDTH-1:0]  issued_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } state_e;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] inst0_q;
  logic [PC_WIDTH-1:0] inst1_q;
  logic [1:0]          mask_q;
  logic [1:0]          mask_d;
  state_e              state;
  logic                cur_slot;
  logic                fire;
  logic                last;
  logic                unused_resv;

  function automatic logic [PC_WIDTH-1:0] slot_pc(input logic [PC_WIDTH-1:0] base,
                                                  input logic slot);
    return base + (slot ? PC_WIDTH'(4) : '0);
  endfunction

  // Reserved header bits carry no meaning for issue.
  assign unused_resv = ^fifo_pop_data[31:2];

  // Slot 1 is current only when it is the sole remaining slot; an empty packet
  // points at slot 0 so the reset-cleared packet presents pc=0/inst=0.
  assign cur_slot  = mask_q[1] & ~mask_q[0];
  assign out_inst  = cur_slot ? inst1_q : inst0_q;
  assign out_pc    = slot_pc(pc_q, cur_slot);

  assign out_valid = rst & ~flush & (mask_q != 2'b00);
  assign fire      = out_valid & out_ready;
  assign last      = fire & (state == HOLD1);
  assign fifo_pop  = rst & ~flush & ~fifo_empty & ((state == EMPTY) | last);

  always_comb begin
    state  = EMPTY;
    mask_d = mask_q;
    case (mask_q)
      2'b00:   state = EMPTY;
      2'b11:   state = HOLD2;
      default: state = HOLD1;
    endcase
    if (flush) begin
      mask_d = 2'b00;
    end else if (fifo_pop) begin
      mask_d = fifo_pop_data[1:0];
    end else if (fire) begin
      mask_d = mask_q & (cur_slot ? 2'b01 : 2'b10);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q     <= 2'b00;
      pc_q       <= '0;
      inst0_q    <= '0;
      inst1_q    <= '0;
      issued_cnt <= '0;
    end else begin
      mask_q <= mask_d;
      if (fifo_pop) begin
        inst1_q <= fifo_pop_data[127:96];
        inst0_q <= fifo_pop_data[95:64];
        pc_q    <= fifo_pop_data[63:32];
      end
      if (fire) begin
        issued_cnt <= issued_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_packet_splitter.sv
// Bench for fetch_packet_splitter: FIFO model plus an expected-instruction queue
// built by expanding each popped packet into its valid slots.
module tb_fetch_packet_splitter;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         fifo_empty;
  logic [127:0] fifo_pop_data;
  logic         fifo_pop;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;
  logic [31:0]  issued_cnt;
  logic         s_fifo_pop;
  logic         s_out_valid;
  logic [31:0]  s_out_pc;
  logic [31:0]  s_out_inst;
  logic [3:0]   s_issued_cnt;

  logic [127:0] fifo_q[$];
  slot_t        exp_q[$];
  int           fire_log[$];
  logic [31:0]  exp_cnt = 0;
  int           pop_cnt = 0;
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;

  logic         m_ev, m_fire, m_ep;
  slot_t        m_s;
  logic [127:0] m_e;

  always #5 clk = ~clk;

  fetch_packet_splitter #(.DATA_WIDTH(128), .PC_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_pop_data(fifo_pop_data), .fifo_pop(fifo_pop), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .issued_cnt(issued_cnt)
  );

  // Narrow-counter twin sees identical stimulus so its counter wraps quickly.
  fetch_packet_splitter #(.DATA_WIDTH(128), .PC_WIDTH(32), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_pop_data(fifo_pop_data), .fifo_pop(s_fifo_pop), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst), .issued_cnt(s_issued_cnt)
  );

  function automatic logic [127:0] mk(input logic [31:0] pc, input logic [31:0] i0,
                                      input logic [31:0] i1, input logic [1:0] m);
    return {i1, i0, pc, 30'($urandom), m};
  endfunction

  function automatic void drive_fifo();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_pop_data = fifo_empty ? {$urandom, $urandom, $urandom, $urandom} : fifo_q[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    drive_fifo();
  end

  // Scoreboard: valid/pop expectations from remaining slots and FIFO occupancy.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end
    m_ev   = rst && !flush && (exp_q.size() != 0);
    m_fire = m_ev && out_ready;
    m_ep   = rst && !flush && (fifo_q.size() != 0) &&
             ((exp_q.size() == 0) || (m_fire && exp_q.size() == 1));
    tests++;
    if (out_valid !== m_ev) begin
      fails++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_ev);
    end
    tests++;
    if (fifo_pop !== m_ep) begin
      fails++;
      $display("FAIL fifo_pop cyc=%0d got=%b exp=%b", cyc, fifo_pop, m_ep);
    end
    tests++;
    if (issued_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL issued_cnt cyc=%0d got=%h exp=%h", cyc, issued_cnt, exp_cnt);
    end
    tests++;
    if (s_issued_cnt !== exp_cnt[3:0]) begin
      fails++;
      $display("FAIL narrow_cnt cyc=%0d got=%h exp=%h", cyc, s_issued_cnt, exp_cnt[3:0]);
    end
    tests++;
    if ({s_fifo_pop, s_out_valid, s_out_pc, s_out_inst} !== {fifo_pop, out_valid, out_pc, out_inst}) begin
      fails++;
      $display("FAIL twin cyc=%0d got=%h exp=%h", cyc, {s_out_pc, s_out_inst}, {out_pc, out_inst});
    end
    if (m_fire) begin
      m_s = exp_q.pop_front();
      tests++;
      if ({out_pc, out_inst} !== m_s) begin
        fails++;
        $display("FAIL issue cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                 cyc, out_pc, out_inst, m_s.pc, m_s.inst);
      end
      exp_cnt = exp_cnt + 1;
      fire_log.push_back(cyc);
    end
    if (m_ep) begin
      m_e = fifo_q.pop_front();
      pop_cnt++;
      if (m_e[0]) exp_q.push_back({m_e[63:32], m_e[95:64]});
      if (m_e[1]) exp_q.push_back({m_e[63:32] + 32'd4, m_e[127:96]});
    end
    if (flush) begin
      exp_q.delete();
      fifo_q.delete();
    end
    cyc++;
  end

  task automatic test_reset();
    fifo_q.push_back(mk(32'h40, 32'h1, 32'h2, 2'b11));
    drive_fifo();
    repeat (3) tick();
    @(negedge clk);
    #2;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    tests++;
    if (fifo_pop !== 1'b0) begin fails++; $display("FAIL rst_pop got=%b exp=0", fifo_pop); end
    tests++;
    if (issued_cnt !== 32'h0) begin fails++; $display("FAIL rst_cnt got=%h exp=0", issued_cnt); end
    tests++;
    if ({out_pc, out_inst} !== 64'h0) begin
      fails++; $display("FAIL rst_data got=%h exp=0", {out_pc, out_inst});
    end
    fifo_q.delete();
    tick();
    drive_fifo();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_pair();
    out_ready = 1'b1;
    fifo_q.push_back(mk(32'h1C000000, 32'hAAAA0001, 32'hBBBB0002, 2'b11));
    drive_fifo();
    @(negedge clk); #2;
    tests++;
    if ({fifo_pop, out_valid} !== 2'b10) begin
      fails++; $display("FAIL pair_load got=%b exp=10", {fifo_pop, out_valid});
    end
    @(negedge clk); #2;
    tests++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h1C000000, 32'hAAAA0001}) begin
      fails++; $display("FAIL pair_slot0 got=%h/%h exp=1c000000/aaaa0001", out_pc, out_inst);
    end
    @(negedge clk); #2;
    tests++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 32'h1C000004, 32'hBBBB0002}) begin
      fails++; $display("FAIL pair_slot1 got=%h/%h exp=1c000004/bbbb0002", out_pc, out_inst);
    end
    tick();
    tests++;
    if (issued_cnt !== 32'd2) begin fails++; $display("FAIL pair_cnt got=%0d exp=2", issued_cnt); end
  endtask

  task automatic test_mask_edge();
    logic [31:0] c0, i1;
    int p0;
    c0 = exp_cnt;
    p0 = pop_cnt;
    i1 = $urandom;
    out_ready = 1'b1;
    fifo_q.push_back(mk(32'h100, $urandom, i1, 2'b10));
    fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b00));
    drive_fifo();
    @(negedge clk); #2;
    @(negedge clk); #2;
    tests++;
    if ({out_valid, fifo_pop, out_pc, out_inst} !== {2'b11, 32'h104, i1}) begin
      fails++; $display("FAIL mask10 got=%b%b %h/%h exp=11 104/%h", out_valid, fifo_pop, out_pc, out_inst, i1);
    end
    @(negedge clk); #2;
    tests++;
    if ({out_valid, fifo_pop} !== 2'b00) begin
      fails++; $display("FAIL mask00 got=%b exp=00", {out_valid, fifo_pop});
    end
    tick();
    tests++;
    if (issued_cnt !== c0 + 32'd1 || pop_cnt != p0 + 2) begin
      fails++; $display("FAIL mask_cnt got=%0d/%0d exp=%0d/%0d", issued_cnt, pop_cnt - p0, c0 + 1, 2);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pop_cnt;
    out_ready = 1'b1;
    fire_log.delete();
    for (int i = 0; i < 3; i++) fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (fire_log.size() != 6 || pop_cnt - p0 != 3) begin
      fails++; $display("FAIL b2b_count got=%0d fires %0d pops exp=6 fires 3 pops", fire_log.size(), pop_cnt - p0);
    end else begin
      tests++;
      if (fire_log[5] - fire_log[0] != 5) begin
        fails++; $display("FAIL b2b_span got=%0d exp=5", fire_log[5] - fire_log[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pc, i0;
    int w;
    pc = $urandom;
    i0 = $urandom;
    out_ready = 1'b0;
    fifo_q.push_back(mk(pc, i0, $urandom, 2'b11));
    fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (w = 0; w < 10 && !out_valid; w++) tick();
    tests++;
    if (!out_valid) begin fails++; $display("FAIL bp_timeout got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      tests++;
      if ({out_valid, fifo_pop, out_pc, out_inst} !== {2'b10, pc, i0}) begin
        fails++; $display("FAIL bp_hold k=%0d got=%b%b %h/%h exp=10 %h/%h", k, out_valid, fifo_pop, out_pc, out_inst, pc, i0);
      end
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL bp_drain got=%0d left exp=0", fifo_q.size() + exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic [31:0] c0;
    out_ready = 1'b0;
    fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int w = 0; w < 10 && !out_valid; w++) tick();
    flush = 1'b1;
    @(negedge clk); #2;
    tests++;
    if ({out_valid, fifo_pop} !== 2'b00) begin
      fails++; $display("FAIL flush_same got=%b exp=00", {out_valid, fifo_pop});
    end
    tick();
    flush = 1'b0;
    drive_fifo();
    @(negedge clk); #2;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_after got=%b exp=0", out_valid); end
    tick();
    c0 = exp_cnt;
    out_ready = 1'b1;
    fifo_q.push_back(mk(32'h200, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int i = 0; i < 20 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (issued_cnt !== c0 + 32'd2) begin
      fails++; $display("FAIL flush_reissue got=%0d exp=%0d", issued_cnt, c0 + 2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc;
    pc = $urandom;
    out_ready = 1'b0;
    fifo_q.push_back(mk(pc, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int w = 0; w < 10 && !out_valid; w++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if ({out_valid, out_pc} !== {1'b1, pc + 32'd4}) begin
      fails++; $display("FAIL hold1 got=%b %h exp=1 %h", out_valid, out_pc, pc + 32'd4);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({out_valid, fifo_pop, issued_cnt} !== 34'h0) begin
      fails++; $display("FAIL rst_mid got=%b%b %h exp=00 0", out_valid, fifo_pop, issued_cnt);
    end
    exp_q.delete();
    fifo_q.delete();
    exp_cnt = 0;
    drive_fifo();
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b1;
    fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int i = 0; i < 20 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (issued_cnt !== 32'd2) begin fails++; $display("FAIL rst_restart got=%0d exp=2", issued_cnt); end
  endtask

  task automatic test_wrap();
    logic [31:0] c0;
    c0 = exp_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'b11));
    drive_fifo();
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (s_issued_cnt !== 4'(c0 + 32'd20) || issued_cnt !== c0 + 32'd20) begin
      fails++; $display("FAIL wrap got=%h/%h exp=%h/%h", s_issued_cnt, issued_cnt, 4'(c0 + 32'd20), c0 + 32'd20);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(1, 0) == 1)
        fifo_q.push_back(mk($urandom, $urandom, $urandom, 2'($urandom)));
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(39, 0) == 0);
      drive_fifo();
      tick();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) tick();
    tests++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL rand_drain got=%0d left exp=0", fifo_q.size() + exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_fifo();
    test_reset();
    test_pair();
    test_mask_edge();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
